frequency_analyzer_scheduler: RTL

FREQUENCY_ANALYZER_SCHEDULER -- requirements
Module: frequency_analyzer_scheduler

---
 rtl/frequency_analyzer_scheduler_pkg.sv | 13 +
 rtl/frequency_analyzer_scheduler_arbiter.sv | 81 ++++++++
 rtl/frequency_analyzer_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/frequency_analyzer_scheduler_pkg.sv
// Shared definitions for the frequency analyzer scheduler: sequencer state
// encoding and the analyzer result width.
package frequency_analyzer_scheduler_pkg;

    localparam int RESULT_W = 32;

    typedef logic [RESULT_W-1:0] result_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN_0 = 2'd1;
    localparam logic [1:0] ST_RUN_1 = 2'd2;

endpackage

// File: rtl/frequency_analyzer_scheduler_arbiter.sv
// Merges the results of the two analyzers into a single valid/ready output
// slot. Each analyzer has a one-deep holding register, and a round-robin pointer arbitrates between them.
module frequency_result_arbiter
    import frequency_analyzer_scheduler_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                result_valid_0,
    input  logic [RESULT_W-1:0] result_0,
    input  logic                result_valid_1,
    input  logic [RESULT_W-1:0] result_1,
    input  logic                frequency_ready,
    output logic                frequency_valid,
    output logic [RESULT_W-1:0] frequency_value,
    output logic                frequency_source,
    output logic                overrun
);

    result_t hold_0;
    result_t hold_1;
    logic    pending_0;
    logic    pending_1;
    logic    pointer;

    logic slot_free;
    logic load;
    logic pick_1;
    logic drain_0;
    logic drain_1;

    // The pointer's own pending wins; otherwise fall through to the other one.
    always_comb begin
        slot_free = !frequency_valid || frequency_ready;
        pick_1    = pointer ? pending_1 : !pending_0;
        load      = slot_free && (pending_0 || pending_1);
        drain_0   = load && !pick_1;
        drain_1   = load && pick_1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_0           <= '0;
            hold_1           <= '0;
            pending_0        <= 1'b0;
            pending_1        <= 1'b0;
            pointer          <= 1'b0;
            frequency_valid  <= 1'b0;
            frequency_value  <= '0;
            frequency_source <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            overrun <= (result_valid_0 && pending_0 && !drain_0) ||
                       (result_valid_1 && pending_1 && !drain_1);

            // A fresh capture re-arms pending even when the old value is drained this edge.
            if (result_valid_0) begin
                hold_0    <= result_0;
                pending_0 <= 1'b1;
            end else if (drain_0) begin
                pending_0 <= 1'b0;
            end

            if (result_valid_1) begin
                hold_1    <= result_1;
                pending_1 <= 1'b1;
            end else if (drain_1) begin
                pending_1 <= 1'b0;
            end

            if (load) begin
                frequency_valid  <= 1'b1;
                frequency_value  <= pick_1 ? hold_1 : hold_0;
                frequency_source <= pick_1;
                pointer          <= !pick_1;
            end else if (frequency_ready) begin
                frequency_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/frequency_analyzer_scheduler.sv
// Ping-pong window sequencer for two frequency analyzers, together with the
// result merger that forwards their counts to a single consumer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no window open; waits for enable, always restarts on analyzer 0
// ST_RUN_0 | analyzer 0 window open, counter runs 0..WINDOW-1
// ST_RUN_1 | analyzer 1 window open, counter runs 0..WINDOW-1
module frequency_analyzer_scheduler
    import frequency_analyzer_scheduler_pkg::*;
#(
    parameter int CLOCK     = 100000000,
    parameter int FREQUENCY = 2000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic                start_analyzer_0,
    output logic                start_analyzer_1,
    output logic                stop_analyzer_0,
    output logic                stop_analyzer_1,
    input  logic                result_valid_0,
    input  logic                result_valid_1,
    input  logic [RESULT_W-1:0] result_0,
    input  logic [RESULT_W-1:0] result_1,
    output logic                frequency_valid,
    output logic [RESULT_W-1:0] frequency_value,
    output logic                frequency_source,
    input  logic                frequency_ready,
    output logic                overrun
);

    localparam int WINDOW = CLOCK / FREQUENCY;
    localparam int CNT_W  = (WINDOW < 2) ? 1 : $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    if (WINDOW < 2) begin : g_window_check
        $error("frequency_analyzer_scheduler: CLOCK/FREQUENCY must be at least 2");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             window_end;

    assign window_end = (count == LAST);

    // Enable is only consulted at IDLE and at window end, so open windows always complete.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            count            <= '0;
            start_analyzer_0 <= 1'b0;
            start_analyzer_1 <= 1'b0;
            stop_analyzer_0  <= 1'b0;
            stop_analyzer_1  <= 1'b0;
        end else begin
            start_analyzer_0 <= 1'b0;
            start_analyzer_1 <= 1'b0;
            stop_analyzer_0  <= 1'b0;
            stop_analyzer_1  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state            <= ST_RUN_0;
                        count            <= '0;
                        start_analyzer_0 <= 1'b1;
                    end
                end
                ST_RUN_0: begin
                    if (window_end) begin
                        stop_analyzer_0 <= 1'b1;
                        count           <= '0;
                        if (enable) begin
                            state            <= ST_RUN_1;
                            start_analyzer_1 <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_RUN_1: begin
                    if (window_end) begin
                        stop_analyzer_1 <= 1'b1;
                        count           <= '0;
                        if (enable) begin
                            state            <= ST_RUN_0;
                            start_analyzer_0 <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    frequency_result_arbiter u_arbiter (
        .clock            (clock),
        .reset            (reset),
        .result_valid_0   (result_valid_0),
        .result_0         (result_0),
        .result_valid_1   (result_valid_1),
        .result_1         (result_1),
        .frequency_ready  (frequency_ready),
        .frequency_valid  (frequency_valid),
        .frequency_value  (frequency_value),
        .frequency_source (frequency_source),
        .overrun          (overrun)
    );

endmodule
